// File: rtl/h264_frame_controller.sv
// Frame sequencer for the intra H.264 encoder core.
// Walks one 4:2:0 frame macroblock by macroblock. For each MB it streams
// 64 luma words and 32 chroma words with their frame-store addresses, then
// paces MBs and frames from the encoder's done flags.
module h264_frame_controller #(
  parameter int IMGWIDTH  = 352,
  parameter int IMGHEIGHT = 288
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        newslice,
  output logic        newline,
  input  logic        xbuffer_DONE,
  input  logic        intra4x4_READYI,
  output logic        intra4x4_STROBEI,
  input  logic        intra8x8cc_READYI,
  output logic        intra8x8cc_STROBEI,
  input  logic        tobytes_STROBE,
  input  logic        tobytes_DONE,
  input  logic        align_VALID,
  output logic [31:0] x,
  output logic [31:0] y,
  output logic [31:0] cx,
  output logic [31:0] cy,
  output logic        cuv
);

  localparam logic [31:0] MBCOLS = 32'(IMGWIDTH / 16);
  localparam logic [31:0] MBROWS = 32'(IMGHEIGHT / 16);

  typedef enum logic [2:0] {
    IDLE,
    MBSTART,
    LUMA,
    CHROMA,
    MBWAIT,
    FRAMEWAIT
  } state_t;

  state_t      state;
  logic [5:0]  lword;
  logic [4:0]  cword;
  logic [31:0] mbx;
  logic [31:0] mby;
  logic        done_seen;
  logic        flush_seen;

  logic        luma_acc;
  logic        chroma_acc;
  logic [5:0]  lnext;
  logic [4:0]  cnext;
  logic [31:0] lx_next;
  logic [31:0] ly_next;
  logic [31:0] cx_next;
  logic [31:0] cy_next;
  logic        last_col;
  logic        last_mb;
  logic [31:0] mbx_next;
  logic [31:0] mby_next;

  // The byte-out strobe has no effect on sequencing.
  logic        unused_tobytes_strobe;
  assign unused_tobytes_strobe = tobytes_STROBE;

  // Strobes follow READYI while streaming; next-word addresses derived from the word index.
  always_comb begin
    intra4x4_STROBEI   = (state == LUMA)   && intra4x4_READYI;
    intra8x8cc_STROBEI = (state == CHROMA) && intra8x8cc_READYI;
    luma_acc   = intra4x4_STROBEI;
    chroma_acc = intra8x8cc_STROBEI;
    lnext = lword + 6'd1;
    cnext = cword + 5'd1;
    // Luma block b = lnext[5:2]: bx = 4*{b2,b0}, by + r = {b3,b1,r1,r0}.
    lx_next = {mbx[27:0], 4'b0000} + {28'b0, lnext[4], lnext[2], 2'b00};
    ly_next = {mby[27:0], 4'b0000} + {28'b0, lnext[5], lnext[3], lnext[1:0]};
    // Chroma: plane = cnext[4], raster block {by,bx} = cnext[3:2], row = cnext[1:0].
    cx_next = {mbx[28:0], 3'b000} + {29'b0, cnext[2], 2'b00};
    cy_next = {mby[28:0], 3'b000} + {29'b0, cnext[3], cnext[1:0]};
    last_col = (mbx == MBCOLS - 32'd1);
    last_mb  = last_col && (mby == MBROWS - 32'd1);
    mbx_next = last_col ? '0 : mbx + 32'd1;
    mby_next = last_col ? mby + 32'd1 : mby;
  end

  // Frame sequencing FSM with registered markers and addresses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lword      <= '0;
      cword      <= '0;
      mbx        <= '0;
      mby        <= '0;
      done_seen  <= 1'b0;
      flush_seen <= 1'b0;
      newslice   <= 1'b0;
      newline    <= 1'b0;
      x          <= '0;
      y          <= '0;
      cx         <= '0;
      cy         <= '0;
      cuv        <= 1'b0;
    end else begin
      newslice <= 1'b0;
      newline  <= 1'b0;
      // Done pulses arriving before they are awaited are remembered.
      if (state != IDLE && xbuffer_DONE) done_seen  <= 1'b1;
      if (state != IDLE && tobytes_DONE) flush_seen <= 1'b1;

      case (state)
        IDLE: begin
          done_seen  <= 1'b0;
          flush_seen <= 1'b0;
          if (start && !align_VALID) begin
            state    <= MBSTART;
            newline  <= (mbx == '0);
            newslice <= (mbx == '0) && (mby == '0);
          end
        end

        MBSTART: begin
          x     <= {mbx[27:0], 4'b0000};
          y     <= {mby[27:0], 4'b0000};
          cx    <= {mbx[28:0], 3'b000};
          cy    <= {mby[28:0], 3'b000};
          cuv   <= 1'b0;
          lword <= '0;
          cword <= '0;
          state <= LUMA;
        end

        LUMA: begin
          if (luma_acc) begin
            lword <= lnext;
            if (lword == 6'd63) begin
              state <= CHROMA;
            end else begin
              x <= lx_next;
              y <= ly_next;
            end
          end
        end

        CHROMA: begin
          if (chroma_acc) begin
            cword <= cnext;
            if (cword == 5'd31) begin
              state <= MBWAIT;
            end else begin
              cx  <= cx_next;
              cy  <= cy_next;
              cuv <= cnext[4];
            end
          end
        end

        MBWAIT: begin
          if (done_seen || xbuffer_DONE) begin
            done_seen <= 1'b0;
            if (last_mb) begin
              state <= FRAMEWAIT;
            end else begin
              mbx      <= mbx_next;
              mby      <= mby_next;
              newline  <= (mbx_next == '0);
              newslice <= 1'b0;
              state    <= MBSTART;
            end
          end
        end

        FRAMEWAIT: begin
          if (flush_seen || tobytes_DONE) begin
            flush_seen <= 1'b0;
            mbx        <= '0;
            mby        <= '0;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_h264_frame_controller.sv
// Directed bench for h264_frame_controller at the default CIF frame size.
module tb_h264_frame_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        newslice;
  logic        newline;
  logic        xbuffer_DONE;
  logic        intra4x4_READYI;
  logic        intra4x4_STROBEI;
  logic        intra8x8cc_READYI;
  logic        intra8x8cc_STROBEI;
  logic        tobytes_STROBE;
  logic        tobytes_DONE;
  logic        align_VALID;
  logic [31:0] x, y, cx, cy;
  logic        cuv;

  int passed = 0;
  int total  = 0;

  h264_frame_controller #(.IMGWIDTH(352), .IMGHEIGHT(288)) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .newslice           (newslice),
    .newline            (newline),
    .xbuffer_DONE       (xbuffer_DONE),
    .intra4x4_READYI    (intra4x4_READYI),
    .intra4x4_STROBEI   (intra4x4_STROBEI),
    .intra8x8cc_READYI  (intra8x8cc_READYI),
    .intra8x8cc_STROBEI (intra8x8cc_STROBEI),
    .tobytes_STROBE     (tobytes_STROBE),
    .tobytes_DONE       (tobytes_DONE),
    .align_VALID        (align_VALID),
    .x                  (x),
    .y                  (y),
    .cx                 (cx),
    .cy                 (cy),
    .cuv                (cuv)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  int cnt_a, cnt_b, cnt_c, edges, cyc;
  logic pst, pnl, pns;

  initial begin
    rst = 1'b1; start = 1'b0; xbuffer_DONE = 1'b0;
    intra4x4_READYI = 1'b1; intra8x8cc_READYI = 1'b1;
    tobytes_STROBE = 1'b0; tobytes_DONE = 1'b0; align_VALID = 1'b0;

    // Reset state
    tick(2);
    check("rst_newslice", newslice, 0);
    check("rst_newline", newline, 0);
    check("rst_strobe_l", intra4x4_STROBEI, 0);
    check("rst_strobe_c", intra8x8cc_STROBEI, 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_cx", cx, 0);
    check("rst_cy", cy, 0);
    check("rst_cuv", cuv, 0);

    // Idle with start low: nothing happens even with READYIs high
    rst = 1'b0;
    cnt_a = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (intra4x4_STROBEI || intra8x8cc_STROBEI || newslice || newline) cnt_a++;
    end
    check("idle_quiet", cnt_a, 0);

    // Start frame: MBSTART markers
    start = 1'b1;
    tick(1);
    check("mb0_newslice", newslice, 1);
    check("mb0_newline", newline, 1);
    check("mbstart_nostrobe", intra4x4_STROBEI, 0);
    tick(1);
    check("w0_strobe", intra4x4_STROBEI, 1);
    check("w0_cstrobe", intra8x8cc_STROBEI, 0);
    check("w0_newslice_gone", newslice, 0);
    check("w0_x", x, 0);
    check("w0_y", y, 0);
    tick(4);
    check("w4_x", x, 4);
    check("w4_y", y, 0);
    tick(4);
    check("w8_x", x, 0);
    check("w8_y", y, 4);
    tick(2);
    // Word 10 is block 2 row 2: (0,6). Stall it for 5 cycles.
    intra4x4_READYI = 1'b0;
    #1;
    check("stall_strobe", intra4x4_STROBEI, 0);
    tick(5);
    check("stall_strobe_held", intra4x4_STROBEI, 0);
    check("stall_x", x, 0);
    check("stall_y", y, 6);
    intra4x4_READYI = 1'b1;
    #1;
    check("resume_strobe", intra4x4_STROBEI, 1);
    check("resume_y", y, 6);
    tick(1);
    check("w11_x", x, 0);
    check("w11_y", y, 7);
    tick(52);
    check("w63_x", x, 12);
    check("w63_y", y, 15);
    check("w63_strobe", intra4x4_STROBEI, 1);

    // Chroma of MB0; an early xbuffer_DONE pulse is latched
    tick(1);
    check("c0_cstrobe", intra8x8cc_STROBEI, 1);
    check("c0_lstrobe", intra4x4_STROBEI, 0);
    check("c0_cuv", cuv, 0);
    check("c0_cx", cx, 0);
    check("c0_cy", cy, 0);
    xbuffer_DONE = 1'b1;
    tick(1);
    xbuffer_DONE = 1'b0;
    tick(4);
    check("c5_cx", cx, 4);
    check("c5_cy", cy, 1);
    tick(11);
    check("c16_cuv", cuv, 1);
    check("c16_cx", cx, 0);
    check("c16_cy", cy, 0);
    tick(15);
    check("c31_cuv", cuv, 1);
    check("c31_cx", cx, 4);
    check("c31_cy", cy, 7);
    tick(1);
    check("mbwait_lstrobe", intra4x4_STROBEI, 0);
    check("mbwait_cstrobe", intra8x8cc_STROBEI, 0);
    tick(1);
    check("mb1_newline", newline, 0);
    check("mb1_newslice", newslice, 0);
    tick(1);
    check("mb1_x", x, 16);
    check("mb1_y", y, 0);
    check("mb1_cx", cx, 8);

    // Run to MB22 (start of second MB row)
    xbuffer_DONE = 1'b1;
    edges = 0; cyc = 0; pst = intra4x4_STROBEI; pnl = 1'b0; pns = 1'b0;
    while (edges < 21 && cyc < 5000) begin
      pnl = newline; pns = newslice; pst = intra4x4_STROBEI;
      tick(1);
      cyc++;
      if (intra4x4_STROBEI && !pst) edges++;
    end
    check("reach_mb22", edges, 21);
    check("mb22_newline", pnl, 1);
    check("mb22_newslice", pns, 0);
    check("mb22_x", x, 0);
    check("mb22_y", y, 16);
    check("mb22_cy", cy, 8);

    // Run to MB395, the last MB
    edges = 0; cyc = 0;
    while (edges < 373 && cyc < 40000) begin
      pst = intra4x4_STROBEI;
      tick(1);
      cyc++;
      if (intra4x4_STROBEI && !pst) edges++;
    end
    check("reach_mb395", edges, 373);
    check("mb395_x", x, 336);
    check("mb395_y", y, 272);
    xbuffer_DONE = 1'b0;

    // Finish last MB; then stall in FRAMEWAIT until tobytes_DONE
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (intra4x4_STROBEI) cnt_a++;
      if (intra8x8cc_STROBEI) cnt_b++;
      if (newslice || newline) cnt_c++;
    end
    check("last_luma_words", cnt_a, 63);
    check("last_chroma_words", cnt_b, 32);
    check("framewait_no_markers", cnt_c, 0);
    check("framewait_lstrobe", intra4x4_STROBEI, 0);

    tobytes_DONE = 1'b1;
    tick(1);
    tobytes_DONE = 1'b0;
    tick(1);
    check("f2_newslice", newslice, 1);
    check("f2_newline", newline, 1);
    tick(1);
    check("f2_x", x, 0);
    check("f2_y", y, 0);
    check("f2_strobe", intra4x4_STROBEI, 1);
    tick(3);
    check("f2_w3_y", y, 3);

    // Reset mid-LUMA aborts to IDLE
    rst = 1'b1;
    tick(1);
    check("abort_strobe", intra4x4_STROBEI, 0);
    check("abort_y", y, 0);
    check("abort_newslice", newslice, 0);

    // Aligner busy holds IDLE despite start
    rst = 1'b0;
    align_VALID = 1'b1;
    cnt_a = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (newslice || intra4x4_STROBEI) cnt_a++;
    end
    check("align_busy_hold", cnt_a, 0);
    align_VALID = 1'b0;
    tick(1);
    check("restart_newslice", newslice, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
